// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter in front of a single memory port, one transaction in flight.
// Latency: grant visible one cycle after the request is sampled in IDLE; done pulses one cycle after m_done.
// Backpressure: requesters hold their request until done; a flush drops the icache result but not the access.
module mem_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  // icache refill port
  input  logic          i_rqst,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flsh,
  output logic          i_done,
  output logic [DW-1:0] i_rdat,
  // dcache port
  input  logic          d_rqst,
  input  logic          d_wena,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdat,
  output logic          d_done,
  output logic [DW-1:0] d_rdat,
  // shared memory port
  output logic          m_rqst,
  output logic          m_wena,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdat,
  input  logic          m_done,
  input  logic [DW-1:0] m_rdat,
  // statistics
  output logic [31:0]   cnt_i,
  output logic [31:0]   cnt_d,
  output logic [31:0]   cnt_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_last_d;   // 1: dcache had the most recent grant; 0: icache
  logic          r_drop;     // icache result is discarded because of a flush
  logic          r_m_rqst;
  logic          r_m_wena;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wdat;
  logic          r_i_done;
  logic          r_d_done;
  logic [DW-1:0] r_i_rdat;
  logic [DW-1:0] r_d_rdat;
  logic [31:0]   r_cnt_i;
  logic [31:0]   r_cnt_d;
  logic [31:0]   r_cnt_busy;

  logic          w_i_elig;
  logic          w_d_elig;
  logic          w_grant_i;
  logic          w_grant_d;

  // Eligibility and round-robin tie break: on a tie the requester not granted last wins.
  always_comb begin
    w_i_elig  = i_rqst & ~i_flsh;
    w_d_elig  = d_rqst;
    w_grant_d = w_d_elig & (~w_i_elig | ~r_last_d);
    w_grant_i = w_i_elig & (~w_d_elig |  r_last_d);
  end

  // Main FSM: grant, hold the memory request until m_done, then pulse done for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_drop   <= 1'b0;
      r_m_rqst <= 1'b0;
      r_m_wena <= 1'b0;
      r_m_addr <= '0;
      r_m_wdat <= '0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_i_rdat <= '0;
      r_d_rdat <= '0;
      r_cnt_i  <= '0;
      r_cnt_d  <= '0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_m_rqst <= 1'b1;
            r_m_addr <= d_addr;
            r_m_wena <= d_wena;
            r_m_wdat <= d_wdat;
            r_last_d <= 1'b1;
            r_drop   <= 1'b0;
            r_cnt_d  <= r_cnt_d + 32'd1;
            r_state  <= BUSY_D;
          end else if (w_grant_i) begin
            r_m_rqst <= 1'b1;
            r_m_addr <= i_addr;
            r_m_wena <= 1'b0;
            r_m_wdat <= '0;
            r_last_d <= 1'b0;
            r_drop   <= 1'b0;
            r_cnt_i  <= r_cnt_i + 32'd1;
            r_state  <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (i_flsh) begin
            r_drop <= 1'b1;
          end
          if (m_done) begin
            r_m_rqst <= 1'b0;
            r_i_rdat <= m_rdat;
            // A flush seen on the very edge entering RESP_I also suppresses done.
            r_i_done <= ~(r_drop | i_flsh);
            r_state  <= RESP_I;
          end
        end
        BUSY_D: begin
          if (m_done) begin
            r_m_rqst <= 1'b0;
            r_d_rdat <= m_rdat;
            r_d_done <= 1'b1;
            r_state  <= RESP_D;
          end
        end
        RESP_I, RESP_D: begin
          r_drop  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_m_rqst <= 1'b0;
          r_drop   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  // Count every cycle the memory request is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_busy <= '0;
    end else if (r_m_rqst) begin
      r_cnt_busy <= r_cnt_busy + 32'd1;
    end
  end

  assign m_rqst   = r_m_rqst;
  assign m_wena   = r_m_wena;
  assign m_addr   = r_m_addr;
  assign m_wdat   = r_m_wdat;
  assign i_done   = r_i_done;
  assign d_done   = r_d_done;
  assign i_rdat   = r_i_rdat;
  assign d_rdat   = r_d_rdat;
  assign cnt_i    = r_cnt_i;
  assign cnt_d    = r_cnt_d;
  assign cnt_busy = r_cnt_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus hand-written corner sequences.
// Inputs are driven and outputs sampled on the falling edge, away from the active rising edge.
// Expected values come from the vector table and from counters kept in the bench.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_rqst;
  logic [63:0] i_addr;
  logic        i_flsh;
  logic        i_done;
  logic [63:0] i_rdat;
  logic        d_rqst;
  logic        d_wena;
  logic [63:0] d_addr;
  logic [63:0] d_wdat;
  logic        d_done;
  logic [63:0] d_rdat;
  logic        m_rqst;
  logic        m_wena;
  logic [63:0] m_addr;
  logic [63:0] m_wdat;
  logic        m_done;
  logic [63:0] m_rdat;
  logic [31:0] cnt_i;
  logic [31:0] cnt_d;
  logic [31:0] cnt_busy;

  mem_arbiter #(.AW(64), .DW(64)) dut (
    .clk(clk), .rst(rst),
    .i_rqst(i_rqst), .i_addr(i_addr), .i_flsh(i_flsh), .i_done(i_done), .i_rdat(i_rdat),
    .d_rqst(d_rqst), .d_wena(d_wena), .d_addr(d_addr), .d_wdat(d_wdat),
    .d_done(d_done), .d_rdat(d_rdat),
    .m_rqst(m_rqst), .m_wena(m_wena), .m_addr(m_addr), .m_wdat(m_wdat),
    .m_done(m_done), .m_rdat(m_rdat),
    .cnt_i(cnt_i), .cnt_d(cnt_d), .cnt_busy(cnt_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          wena;
    bit          flsh;       // pulse i_flsh during the second busy cycle
    logic [63:0] addr;
    logic [63:0] wdat;
    logic [63:0] rdat;
    int          lat;        // number of cycles m_rqst stays high
    bit          exp_done;
    bit          exp_mwena;
    logic [63:0] exp_mwdat;
  } vec_t;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          exp_ci = 0;
  int          exp_cd = 0;
  int          exp_busy = 0;
  logic [63:0] exp_i_rdat = '0;
  logic [63:0] exp_d_rdat = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   w;
    logic hold_ok;
    if (v.is_d) begin
      d_rqst = 1'b1; d_wena = v.wena; d_addr = v.addr; d_wdat = v.wdat;
    end else begin
      i_rqst = 1'b1; i_addr = v.addr;
      d_wena = 1'b1; d_wdat = 64'hBEEF;   // must not leak onto the memory port
    end
    w = 0;
    do begin @(negedge clk); w++; end while (!m_rqst && w < 8);
    check({tag, "_grant_lat"}, 64'(w), 64'd1);
    check({tag, "_m_addr"}, m_addr, v.addr);
    check({tag, "_m_wena"}, {63'd0, m_wena}, {63'd0, v.exp_mwena});
    check({tag, "_m_wdat"}, m_wdat, v.exp_mwdat);
    if (v.is_d) exp_cd++; else exp_ci++;
    check({tag, "_cnt_id"}, {cnt_i, cnt_d}, {32'(exp_ci), 32'(exp_cd)});
    hold_ok = 1'b1;
    for (int k = 1; k < v.lat; k++) begin
      i_flsh = (v.flsh && k == 1);
      @(negedge clk);
      hold_ok &= m_rqst && (m_addr == v.addr) && (m_wena == v.exp_mwena) && (m_wdat == v.exp_mwdat);
    end
    i_flsh = 1'b0;
    check({tag, "_busy_hold"}, {63'd0, hold_ok}, 64'd1);
    m_done = 1'b1; m_rdat = v.rdat;
    @(negedge clk);
    m_done = 1'b0; m_rdat = 64'h5A5A_5A5A_5A5A_5A5A;
    if (v.is_d) exp_d_rdat = v.rdat; else exp_i_rdat = v.rdat;
    check({tag, "_done_pulse"}, {62'd0, i_done, d_done}, v.is_d ? 64'b01 : {62'd0, v.exp_done, 1'b0});
    check({tag, "_rdat"}, i_rdat ^ {d_rdat[31:0], d_rdat[63:32]},
          exp_i_rdat ^ {exp_d_rdat[31:0], exp_d_rdat[63:32]});
    check({tag, "_m_rqst_resp"}, {63'd0, m_rqst}, 64'd0);
    i_rqst = 1'b0; d_rqst = 1'b0;
    @(negedge clk);
    check({tag, "_done_cleared"}, {62'd0, i_done, d_done}, 64'd0);
    exp_busy += v.lat;
    check({tag, "_cnt_busy"}, 64'(cnt_busy), 64'(exp_busy));
  endtask

  vec_t        vt[6];
  logic [63:0] tie_ord[4];
  int          w;

  initial begin
    vt[0] = '{0, 0, 0, 64'h1000, 64'h0, 64'hDEADBEEF, 4, 1, 0, 64'h0};
    vt[1] = '{1, 1, 0, 64'h2008, 64'h55, 64'h1234, 3, 1, 1, 64'h55};
    vt[2] = '{1, 0, 0, 64'h3000, 64'hAAAA, 64'hCAFE, 1, 1, 0, 64'hAAAA};
    vt[3] = '{0, 0, 1, 64'h40, 64'h0, 64'h0BAD_F00D, 5, 0, 0, 64'h0};
    vt[4] = '{0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'h1111_2222_3333_4444, 5, 1, 0, 64'h0};
    vt[5] = '{1, 0, 0, 64'h8, 64'h77, 64'h5555, 5, 1, 0, 64'h77};
    tie_ord[0] = 64'hD0; tie_ord[1] = 64'hA0; tie_ord[2] = 64'hD0; tie_ord[3] = 64'hA0;

    rst = 1'b1; i_rqst = 1'b0; i_addr = '0; i_flsh = 1'b0;
    d_rqst = 1'b0; d_wena = 1'b0; d_addr = '0; d_wdat = '0;
    m_done = 1'b0; m_rdat = '0;
    #1;
    check("rst_ctrl", {60'd0, m_rqst, m_wena, i_done, d_done}, 64'd0);
    check("rst_data", m_addr | m_wdat | i_rdat | d_rdat, 64'd0);
    check("rst_cnt", 64'(cnt_i) | 64'(cnt_d) | 64'(cnt_busy), 64'd0);
    @(negedge clk);

    // Tie right out of reset: d must win first, then strict alternation.
    rst = 1'b0;
    i_rqst = 1'b1; i_addr = 64'hA0;
    d_rqst = 1'b1; d_addr = 64'hD0; d_wena = 1'b0; d_wdat = '0;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      do begin @(negedge clk); w++; end while (!m_rqst && w < 8);
      if (t == 0) check("tie_first_edge_grant", 64'(w), 64'd1);
      check($sformatf("tie_grant%0d", t), m_addr, tie_ord[t]);
      m_done = 1'b1; m_rdat = 64'(t + 100);
      @(negedge clk);
      m_done = 1'b0;
      check($sformatf("tie_done%0d", t), {62'd0, i_done, d_done}, (t % 2 == 0) ? 64'b01 : 64'b10);
      check($sformatf("tie_no_overlap%0d", t), {63'd0, m_rqst}, 64'd0);
    end
    i_rqst = 1'b0; d_rqst = 1'b0;
    exp_ci = 2; exp_cd = 2; exp_busy = 4;
    exp_d_rdat = 64'd102; exp_i_rdat = 64'd103;
    @(negedge clk);
    check("tie_counts", {cnt_i, cnt_d}, {32'd2, 32'd2});
    check("tie_busy", 64'(cnt_busy), 64'd4);

    for (int i = 0; i < 6; i++) run_txn(vt[i], $sformatf("vec%0d", i));

    // Flush while idle blocks the icache request until it drops.
    i_rqst = 1'b1; i_addr = 64'h500; i_flsh = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("flush_idle_blocked", {63'd0, m_rqst}, 64'd0);
    i_flsh = 1'b0;
    @(negedge clk);
    check("flush_idle_release", {m_rqst, m_addr[62:0]}, {1'b1, 63'h500});
    exp_ci++;
    m_done = 1'b1; m_rdat = 64'h600;
    @(negedge clk);
    m_done = 1'b0; exp_i_rdat = 64'h600; exp_busy += 1;
    check("flush_idle_done", {62'd0, i_done, d_done}, 64'b10);
    i_rqst = 1'b0;
    @(negedge clk);

    // Flush during BUSY_I with a dcache request arriving meanwhile.
    i_rqst = 1'b1; i_addr = 64'h700;
    @(negedge clk);
    check("fbusy_grant_i", {m_rqst, m_addr[62:0]}, {1'b1, 63'h700});
    exp_ci++;
    i_flsh = 1'b1; d_rqst = 1'b1; d_addr = 64'h800; d_wena = 1'b0; d_wdat = 64'h0;
    @(negedge clk);
    i_flsh = 1'b0; i_rqst = 1'b0;
    @(negedge clk);
    check("fbusy_held", {m_rqst, m_addr[62:0]}, {1'b1, 63'h700});
    m_done = 1'b1; m_rdat = 64'h77AA;
    @(negedge clk);
    m_done = 1'b0; exp_i_rdat = 64'h77AA; exp_busy += 3;
    check("fbusy_no_i_done", {62'd0, i_done, d_done}, 64'd0);
    check("fbusy_i_rdat", i_rdat, exp_i_rdat);
    check("fbusy_resp", {63'd0, m_rqst}, 64'd0);
    w = 0;
    do begin @(negedge clk); w++; end while (!m_rqst && w < 8);
    check("fbusy_then_d", {m_rqst, m_addr[62:0]}, {1'b1, 63'h800});
    exp_cd++;
    m_done = 1'b1; m_rdat = 64'h88;
    @(negedge clk);
    m_done = 1'b0; exp_d_rdat = 64'h88; exp_busy += 1;
    check("fbusy_d_done", {62'd0, i_done, d_done}, 64'b01);
    d_rqst = 1'b0;
    @(negedge clk);
    check("final_counts", {cnt_i, cnt_d}, {32'(exp_ci), 32'(exp_cd)});
    check("final_busy", 64'(cnt_busy), 64'(exp_busy));

    // Asynchronous reset in the middle of a dcache write.
    d_rqst = 1'b1; d_addr = 64'h9000; d_wena = 1'b1; d_wdat = 64'h99;
    @(negedge clk);
    check("arst_busy_d", {m_rqst, m_wena, m_addr[61:0]}, {2'b11, 62'h9000});
    #2 rst = 1'b1;
    #1;
    check("arst_ctrl", {60'd0, m_rqst, m_wena, i_done, d_done}, 64'd0);
    check("arst_data", m_addr | m_wdat | i_rdat | d_rdat, 64'd0);
    check("arst_cnt", 64'(cnt_i) | 64'(cnt_d) | 64'(cnt_busy), 64'd0);
    d_rqst = 1'b0; m_done = 1'b1; m_rdat = 64'hFFFF;
    @(negedge clk);
    m_done = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("arst_no_done", {61'd0, m_rqst, i_done, d_done}, 64'd0);
    check("arst_d_rdat", d_rdat, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
